lsu_mem_ctrl: RTL and testbench
===============================

# lsu_mem_ctrl

Load/store controller that sits directly upstream of the word-addressed data memory. It accepts RV32I load/store requests using byte addresses and `funct3` encodings. It translates each request into word-level memory read and write cycles, including a read-modify-write sequence for SB/SH. It returns aligned, sign- or zero-extended load data, or an error flag, to the pipeline through a valid/ready handshake.

## Interface
Parameters:
- `DEPTH`, 64: number of 32-bit words in the attached memory; word index must be `< DEPTH`.

Ports:
- `clk`  in  1  clock; all state updates on rising edge.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  controller can accept; high only in IDLE.
- `req_we`  in  1  1 = store, 0 = load.
- `req_funct3`  in  3  loads 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; stores 000 SB, 001 SH, 010 SW.
- `req_addr`  in  32  byte address.
- `req_wdata`  in  32  store data, low bits significant for SB/SH.
- `resp_valid`  out  1  one-cycle response pulse.
- `resp_rdata`  out  32  extended load data; 0 for stores and errors.
- `resp_err`  out  1  misaligned, out-of-range or illegal funct3.
- `mem_addr`  out  32  word index = `req_addr[31:2]`, zero-extended.
- `mem_rd_en`  out  1  memory read enable.
- `mem_wr_en`  out  1  memory write enable; memory writes on the falling edge inside the cycle.
- `mem_wr_data`  out  32  word to write.
- `mem_rdata`  in  32  combinational memory read data.

## Operation
- **States:** IDLE, RD, WR, DONE.
- **Accept:** the request is latched into internal registers (addr, we, funct3, wdata) when `req_valid && req_ready`. Request inputs are ignored at all other times.
- **Error check at accept:**
  - Halfword with `addr[0]=1` is an error.
  - Word with `addr[1:0]!=0` is an error.
  - `addr[31:2] >= DEPTH` is an error.
  - A funct3 not listed above is an error.
  - Error requests go IDLE→DONE with `resp_err=1`, `resp_rdata=0`, and no memory enable ever asserted.
- **State paths:**
  - Load: IDLE→RD→DONE.
  - SW: IDLE→WR→DONE.
  - SB/SH: IDLE→RD→WR→DONE.
  - DONE→IDLE unconditionally.
- **RD:** `mem_rd_en=1` and `mem_addr` = latched word index. `mem_rdata` is captured into a word register on the rising edge that leaves RD.
- **Load extraction (little-endian):**
  - Byte lane = `addr[1:0]`; halfword = `addr[1]` selects bits [31:16] or [15:0].
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word through unchanged.
- **Store merge:**
  - SW writes `req_wdata` unchanged.
  - SB replaces byte lane `addr[1:0]` of the captured word with `wdata[7:0]`.
  - SH replaces halfword `addr[1]` with `wdata[15:0]`.
  - All other bits keep the captured value.
- **WR:** `mem_wr_en=1`, with `mem_wr_data` = merged word and `mem_addr` = latched word index.
- **DONE:** `resp_valid=1` for exactly one cycle, with `resp_rdata` and `resp_err` valid in the same cycle. No back-pressure is applied on the response side.
- **Enables:** `mem_rd_en` and `mem_wr_en` are decoded from state only. They are never both high, and both are 0 in IDLE and DONE.

## Timing
- **Reset:** asserting `rst_n` low at any time forces IDLE immediately. It also clears all latched registers and drives these outputs to 0: `req_ready`, `resp_valid`, `resp_rdata`, `resp_err`, `mem_addr`, `mem_rd_en`, `mem_wr_en`, `mem_wr_data`.
- **After reset release:** `req_ready=1` (IDLE) from the first cycle with `rst_n` high.
- **Reset mid-operation:** the operation is aborted. No response is produced, and `mem_wr_en` drops asynchronously. If reset lands in the WR cycle before its falling edge, no write occurs.
- **Latency from the accept edge to `resp_valid` high:**
  - Error: 1 cycle.
  - Load / SW: 2 cycles.
  - SB/SH: 3 cycles.
- **Throughput:** the next request is accepted in the cycle after DONE. Minimum spacing is 2 cycles for errors, 3 for load/SW and 4 for SB/SH.
- **Held inputs:** `req_valid` held high while `req_ready=0` has no effect. `req_addr` and `req_wdata` may change freely after acceptance.
- **`mem_addr`:** stable throughout RD and WR of one request. It holds its last value in IDLE/DONE.
- **`resp_rdata`, `resp_err`:** registered. They are 0 outside DONE.

## Test plan
- **Reset:** assert `rst_n=0` mid-RD of a load → all outputs 0 immediately; after release `req_ready=1`, no `resp_valid`.
- **SW then LW:** SW addr 0x10, data 0xDEADBEEF → `mem_wr_en` pulse with `mem_addr=4`, `mem_wr_data=0xDEADBEEF`; then LW 0x10 → `resp_rdata=0xDEADBEEF` 2 cycles after accept.
- **Sub-word loads on word 0x8000F0FF at addr 0x20:**
  - LB 0x20 → 0xFFFFFFFF.
  - LBU 0x21 → 0x000000F0.
  - LH 0x22 → 0xFFFF8000.
  - LHU 0x22 → 0x00008000.
- **SB/SH merge:** on word 0x11223344 at 0x30, SB 0x31 data 0xAB → written 0x1122AB44 via RD then WR, 3-cycle latency; SH 0x32 data 0xCAFE → 0xCAFEAB44.
- **Errors:**
  - LH 0x01 → `resp_err=1`.
  - SW 0x06 → `resp_err=1`.
  - LW 0x100 with DEPTH=64 → `resp_err=1`.
  - funct3=011 → `resp_err=1`.
  - In every case: 1-cycle latency, no `mem_rd_en`/`mem_wr_en` pulse, memory contents unchanged.
- **Back-to-back:** `req_valid` held high with 3 queued LW requests → each accepted only in IDLE; exactly 3 `resp_valid` pulses spaced 3 cycles apart.

Source files
------------

// File: rtl/lsu_mem_ctrl_if.sv
// rtl/lsu_mem_ctrl_if.sv - request/response/memory bus of the load/store controller
//
// Purpose: bundles the pipeline-side request/response handshake and the
//          word-addressed data memory port of lsu_mem_ctrl.
// Signals (slave = controller view):
//   req_valid, req_we, req_funct3[2:0], req_addr[31:0], req_wdata[31:0]  in
//   req_ready                                                            out
//   resp_valid, resp_rdata[31:0], resp_err                               out
//   mem_addr[31:0], mem_rd_en, mem_wr_en, mem_wr_data[31:0]              out
//   mem_rdata[31:0]                                                      in
interface lsu_mem_ctrl_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] mem_addr;
  logic        mem_rd_en;
  logic        mem_wr_en;
  logic [31:0] mem_wr_data;
  logic [31:0] mem_rdata;

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rdata,
    output req_ready, resp_valid, resp_rdata, resp_err,
           mem_addr, mem_rd_en, mem_wr_en, mem_wr_data
  );

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rdata,
    input  req_ready, resp_valid, resp_rdata, resp_err,
           mem_addr, mem_rd_en, mem_wr_en, mem_wr_data
  );
endinterface

// File: rtl/lsu_mem_ctrl.sv
// rtl/lsu_mem_ctrl.sv - RV32I load/store controller in front of a word-addressed memory
//
// Purpose: accepts byte-addressed loads/stores, turns them into word read and
//          write cycles (read-modify-write for SB/SH) and returns extended load
//          data or an error flag as a one-cycle response pulse.
// Ports:
//   clk    in  clock, rising edge
//   rst_n  in  asynchronous active-low reset
//   bus    lsu_mem_ctrl_if.slave  request/response handshake and memory port
// Parameters:
//   DEPTH  number of 32-bit words in the attached memory
module lsu_mem_ctrl #(
  parameter int DEPTH = 64
) (
  input  logic          clk,
  input  logic          rst_n,
  lsu_mem_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [1:0]  lane_q, lane_d;
  logic        we_q, we_d;
  logic [2:0]  funct3_q, funct3_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] word_q, word_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] resp_rdata_q, resp_rdata_d;
  logic        resp_err_q, resp_err_d;

  logic        accept;
  logic        req_err;

  function automatic logic check_err(input logic we, input logic [2:0] f3,
                                     input logic [31:0] addr);
    logic legal;
    logic misaligned;
    logic out_of_range;
    if (we) legal = (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b010);
    else    legal = (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b010) ||
                    (f3 == 3'b100) || (f3 == 3'b101);
    // funct3[1:0] encodes the access size for every legal opcode
    misaligned   = ((f3[1:0] == 2'b01) && addr[0]) ||
                   ((f3[1:0] == 2'b10) && (addr[1:0] != 2'b00));
    out_of_range = ({2'b00, addr[31:2]} >= 32'(DEPTH));
    return !legal || misaligned || out_of_range;
  endfunction

  function automatic logic [31:0] load_extract(input logic [31:0] word,
                                               input logic [2:0] f3,
                                               input logic [1:0] lane);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] res;
    case (lane)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      default: b = word[31:24];
    endcase
    h = lane[1] ? word[31:16] : word[15:0];
    case (f3)
      3'b000:  res = {{24{b[7]}}, b};
      3'b001:  res = {{16{h[15]}}, h};
      3'b100:  res = {24'h0, b};
      3'b101:  res = {16'h0, h};
      default: res = word;
    endcase
    return res;
  endfunction

  function automatic logic [31:0] store_merge(input logic [31:0] word,
                                              input logic [2:0] f3,
                                              input logic [1:0] lane,
                                              input logic [31:0] wdata);
    logic [31:0] res;
    res = word;
    case (f3)
      3'b000: begin
        case (lane)
          2'd0:    res[7:0]   = wdata[7:0];
          2'd1:    res[15:8]  = wdata[7:0];
          2'd2:    res[23:16] = wdata[7:0];
          default: res[31:24] = wdata[7:0];
        endcase
      end
      3'b001: begin
        if (lane[1]) res[31:16] = wdata[15:0];
        else         res[15:0]  = wdata[15:0];
      end
      // SW never visits RD, so the captured word is stale and fully replaced
      default: res = wdata;
    endcase
    return res;
  endfunction

  assign accept  = bus.req_valid && bus.req_ready;
  assign req_err = check_err(bus.req_we, bus.req_funct3, bus.req_addr);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (req_err)                                    state_d = DONE;
          else if (bus.req_we && bus.req_funct3 == 3'b010) state_d = WR;
          else                                            state_d = RD;
        end
      end
      RD:      state_d = we_q ? WR : DONE;
      WR:      state_d = DONE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lane_q       <= 2'b00;
      we_q         <= 1'b0;
      funct3_q     <= 3'b000;
      wdata_q      <= 32'h0;
      word_q       <= 32'h0;
      mem_addr_q   <= 32'h0;
      resp_rdata_q <= 32'h0;
      resp_err_q   <= 1'b0;
    end else begin
      lane_q       <= lane_d;
      we_q         <= we_d;
      funct3_q     <= funct3_d;
      wdata_q      <= wdata_d;
      word_q       <= word_d;
      mem_addr_q   <= mem_addr_d;
      resp_rdata_q <= resp_rdata_d;
      resp_err_q   <= resp_err_d;
    end
  end

  always_comb begin
    lane_d       = lane_q;
    we_d         = we_q;
    funct3_d     = funct3_q;
    wdata_d      = wdata_q;
    word_d       = word_q;
    mem_addr_d   = mem_addr_q;
    // response fields are only non-zero during the DONE cycle
    resp_rdata_d = 32'h0;
    resp_err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          lane_d   = bus.req_addr[1:0];
          we_d     = bus.req_we;
          funct3_d = bus.req_funct3;
          wdata_d  = bus.req_wdata;
          // an erroring request never touches memory, so mem_addr keeps
          // pointing at the last real access
          if (req_err) resp_err_d = 1'b1;
          else         mem_addr_d = {2'b00, bus.req_addr[31:2]};
        end
      end
      RD: begin
        word_d = bus.mem_rdata;
        if (!we_q) resp_rdata_d = load_extract(bus.mem_rdata, funct3_q, lane_q);
      end
      default: ;
    endcase
  end

  // Outputs decoded from state
  always_comb begin
    // req_ready is gated by rst_n so it reads 0 while reset is held
    bus.req_ready   = rst_n && (state_q == IDLE);
    bus.mem_rd_en   = (state_q == RD);
    bus.mem_wr_en   = (state_q == WR);
    bus.mem_wr_data = (state_q == WR) ? store_merge(word_q, funct3_q, lane_q, wdata_q)
                                      : 32'h0;
    bus.resp_valid  = (state_q == DONE);
    bus.resp_rdata  = resp_rdata_q;
    bus.resp_err    = resp_err_q;
    bus.mem_addr    = mem_addr_q;
  end

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// tb/tb_lsu_mem_ctrl.sv - scoreboard testbench for lsu_mem_ctrl
module tb_lsu_mem_ctrl;
  localparam int DEPTH = 64;
  localparam int AW    = $clog2(DEPTH);

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   cyc   = 0;
  int   total = 0;
  int   bad   = 0;

  lsu_mem_ctrl_if bus();

  lsu_mem_ctrl #(.DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Memory: combinational read, write on the falling edge
  logic [31:0] mem [DEPTH];
  assign bus.mem_rdata = (bus.mem_addr < 32'(DEPTH)) ? mem[bus.mem_addr[AW-1:0]] : 32'h0;
  always @(negedge clk) if (bus.mem_wr_en) mem[bus.mem_addr[AW-1:0]] <= bus.mem_wr_data;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          issue_cyc;
    int          lat;
  } resp_t;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  resp_t       exp_resp[$];
  logic [31:0] exp_rd[$];
  wr_t         exp_wr[$];
  int          resp_log[$];
  logic [31:0] ref_mem [DEPTH];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %08h expected %08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name, input string what);
    total++;
    bad++;
    $display("FAIL %s: %s (cycle %0d)", name, what, cyc);
  endtask

  // Reference model: expected effect of one request from the ISA rules
  task automatic model(input logic we, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd);
    resp_t       r;
    wr_t         w;
    int          size;
    int          sh;
    logic        legal;
    logic [31:0] widx;
    logic [31:0] old;
    logic [31:0] mask;
    logic [31:0] v;
    widx  = a / 4;
    sh    = 8 * int'(a % 4);
    size  = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
    legal = we ? (f3 <= 3'd2) : (f3 <= 3'd2 || f3 == 3'd4 || f3 == 3'd5);
    r.issue_cyc = cyc;
    r.rdata = 32'h0;
    r.err   = !legal || (a % size != 0) || (widx >= 32'(DEPTH));
    if (r.err) begin
      r.lat = 1;
    end else begin
      old = ref_mem[widx[AW-1:0]];
      if (!we) begin
        r.lat = 2;
        exp_rd.push_back(widx);
        v = old >> sh;
        if (size == 1) begin
          v = v & 32'hFF;
          if (!f3[2] && v >= 32'h80) v = v | 32'hFFFF_FF00;
        end else if (size == 2) begin
          v = v & 32'hFFFF;
          if (!f3[2] && v >= 32'h8000) v = v | 32'hFFFF_0000;
        end
        r.rdata = v;
      end else begin
        if (size == 4) begin
          r.lat  = 2;
          w.data = wd;
        end else begin
          r.lat  = 3;
          exp_rd.push_back(widx);
          mask   = ((size == 1) ? 32'hFF : 32'hFFFF) << sh;
          w.data = (old & ~mask) | ((wd << sh) & mask);
        end
        w.addr = widx;
        exp_wr.push_back(w);
        ref_mem[widx[AW-1:0]] = w.data;
      end
    end
    exp_resp.push_back(r);
  endtask

  // Monitor: compares every DUT memory cycle and response against the queues
  resp_t mon_r;
  wr_t   mon_w;
  always @(negedge clk) begin
    if (rst_n) begin
      chk("rd_wr_exclusive", {31'b0, bus.mem_rd_en & bus.mem_wr_en}, 32'h0);
      if (bus.mem_rd_en) begin
        if (exp_rd.size() == 0) fail_now("unexpected_rd", $sformatf("mem_rd_en at addr %0d, required none", bus.mem_addr));
        else chk("rd_addr", bus.mem_addr, exp_rd.pop_front());
      end
      if (bus.mem_wr_en) begin
        if (exp_wr.size() == 0) fail_now("unexpected_wr", $sformatf("mem_wr_en at addr %0d, required none", bus.mem_addr));
        else begin
          mon_w = exp_wr.pop_front();
          chk("wr_addr", bus.mem_addr, mon_w.addr);
          chk("wr_data", bus.mem_wr_data, mon_w.data);
        end
      end
      if (bus.resp_valid) begin
        resp_log.push_back(cyc);
        if (exp_resp.size() == 0) fail_now("unexpected_resp", "resp_valid with no request outstanding");
        else begin
          mon_r = exp_resp.pop_front();
          chk("resp_rdata", bus.resp_rdata, mon_r.rdata);
          chk("resp_err", {31'b0, bus.resp_err}, {31'b0, mon_r.err});
          chk("resp_latency", 32'(cyc - mon_r.issue_cyc), 32'(mon_r.lat));
        end
      end else begin
        chk("resp_idle_zero", bus.resp_rdata | {31'b0, bus.resp_err}, 32'h0);
      end
    end
  end

  // Called at a falling edge; waits for req_ready, presents the request for one edge
  task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd, input bit hold);
    int n = 0;
    while (!bus.req_ready) begin
      if (n == 20) begin
        fail_now("ready_timeout", "req_ready stayed 0 for 20 cycles, required 1");
        return;
      end
      n++;
      @(negedge clk);
    end
    bus.req_valid  = 1'b1;
    bus.req_we     = we;
    bus.req_funct3 = f3;
    bus.req_addr   = a;
    bus.req_wdata  = wd;
    model(we, f3, a, wd);
    @(negedge clk);
    if (!hold) bus.req_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_resp.size() != 0 && n < 50) begin
      n++;
      @(negedge clk);
    end
    if (exp_resp.size() != 0) fail_now("drain_timeout", "responses still outstanding after 50 cycles");
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_req_ready"},   {31'b0, bus.req_ready},  32'h0);
    chk({tag, "_resp_valid"},  {31'b0, bus.resp_valid}, 32'h0);
    chk({tag, "_resp_rdata"},  bus.resp_rdata,          32'h0);
    chk({tag, "_resp_err"},    {31'b0, bus.resp_err},   32'h0);
    chk({tag, "_mem_addr"},    bus.mem_addr,            32'h0);
    chk({tag, "_mem_rd_en"},   {31'b0, bus.mem_rd_en},  32'h0);
    chk({tag, "_mem_wr_en"},   {31'b0, bus.mem_wr_en},  32'h0);
    chk({tag, "_mem_wr_data"}, bus.mem_wr_data,         32'h0);
  endtask

  logic [2:0]  lf [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
  logic        r_we;
  logic [2:0]  r_f3;
  logic [31:0] r_addr;

  initial begin
    bus.req_valid  = 1'b0;
    bus.req_we     = 1'b0;
    bus.req_funct3 = 3'b000;
    bus.req_addr   = 32'h0;
    bus.req_wdata  = 32'h0;
    repeat (2) @(negedge clk);
    check_all_zero("por");
    #2 rst_n = 1'b1;
    #1 chk("ready_after_por", {31'b0, bus.req_ready}, 32'h1);
    @(negedge clk);

    // Fill memory with random words
    for (int i = 0; i < DEPTH; i++) issue(1'b1, 3'b010, 32'(i * 4), $urandom, 1'b0);

    // SW then LW
    issue(1'b1, 3'b010, 32'h10, 32'hDEAD_BEEF, 1'b0);
    issue(1'b0, 3'b010, 32'h10, 32'h0, 1'b0);

    // Sub-word loads
    issue(1'b1, 3'b010, 32'h20, 32'h8000_F0FF, 1'b0);
    issue(1'b0, 3'b000, 32'h20, 32'h0, 1'b0);
    issue(1'b0, 3'b100, 32'h21, 32'h0, 1'b0);
    issue(1'b0, 3'b001, 32'h22, 32'h0, 1'b0);
    issue(1'b0, 3'b101, 32'h22, 32'h0, 1'b0);

    // SB / SH merge
    issue(1'b1, 3'b010, 32'h30, 32'h1122_3344, 1'b0);
    issue(1'b1, 3'b000, 32'h31, 32'h0000_00AB, 1'b0);
    issue(1'b1, 3'b001, 32'h32, 32'h0000_CAFE, 1'b0);
    issue(1'b0, 3'b010, 32'h30, 32'h0, 1'b0);

    // Errors
    issue(1'b0, 3'b001, 32'h01,  32'h0, 1'b0);
    issue(1'b1, 3'b010, 32'h06,  32'h5555_5555, 1'b0);
    issue(1'b0, 3'b010, 32'h100, 32'h0, 1'b0);
    issue(1'b0, 3'b011, 32'h00,  32'h0, 1'b0);
    issue(1'b1, 3'b100, 32'h00,  32'h1234_5678, 1'b0);

    // Back-to-back with req_valid held high
    drain();
    resp_log.delete();
    issue(1'b0, 3'b010, 32'h04, 32'h0, 1'b1);
    issue(1'b0, 3'b010, 32'h08, 32'h0, 1'b1);
    issue(1'b0, 3'b010, 32'h0C, 32'h0, 1'b0);
    drain();
    repeat (3) @(negedge clk);
    chk("b2b_resp_count", 32'(resp_log.size()), 32'd3);
    if (resp_log.size() == 3) begin
      chk("b2b_spacing_1", 32'(resp_log[1] - resp_log[0]), 32'd3);
      chk("b2b_spacing_2", 32'(resp_log[2] - resp_log[1]), 32'd3);
    end

    // Reset in the middle of a load's RD cycle
    issue(1'b0, 3'b010, 32'h40, 32'h0, 1'b0);
    #2 rst_n = 1'b0;
    #1 check_all_zero("mid_rd");
    exp_resp.delete();
    exp_rd.delete();
    exp_wr.delete();
    @(negedge clk);
    #2 rst_n = 1'b1;
    #1 chk("ready_after_rst", {31'b0, bus.req_ready}, 32'h1);
    @(negedge clk);
    repeat (4) @(negedge clk);

    // Randomized traffic, request fields scrambled while idle
    for (int i = 0; i < 250; i++) begin
      repeat ($urandom_range(0, 2)) begin
        bus.req_addr  = $urandom;
        bus.req_wdata = $urandom;
        @(negedge clk);
      end
      r_we = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) != 0) r_f3 = r_we ? 3'($urandom_range(0, 2)) : lf[$urandom_range(0, 4)];
      else                           r_f3 = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 7) == 0) r_addr = $urandom;
      else                           r_addr = 32'($urandom_range(0, 4 * DEPTH + 7));
      issue(r_we, r_f3, r_addr, $urandom, 1'b0);
    end

    drain();
    repeat (2) @(negedge clk);
    chk("pending_rd", 32'(exp_rd.size()), 32'd0);
    chk("pending_wr", 32'(exp_wr.size()), 32'd0);
    for (int i = 0; i < DEPTH; i++) chk($sformatf("mem_word_%0d", i), mem[i], ref_mem[i]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
